binario_para_bcd: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/binario_para_bcd.sv | 91 +++++++++
 tb/tb_binario_para_bcd.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/binario_para_bcd.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Start/busy/done handshake; bcd/estouro hold their value between conversions.
module binario_para_bcd #(
   parameter int unsigned LARGURA_BIN = 8,
   parameter int unsigned DIGITOS     = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     inicio,
   input  logic [LARGURA_BIN-1:0]   binario,
   output logic                     ocupado,
   output logic                     pronto,
   output logic [4*DIGITOS-1:0]     bcd,
   output logic                     estouro
);

   localparam int unsigned LarguraCont = $clog2(LARGURA_BIN + 1);
   localparam logic [LarguraCont-1:0] ContInicial = LarguraCont'(LARGURA_BIN);
   localparam logic [LarguraCont-1:0] ContUm      = LarguraCont'(1);

   typedef enum logic {
      Ocioso,
      Converte
   } estado_t;

   estado_t                  estado_q;
   logic [LARGURA_BIN-1:0]   desloc_q;
   logic [LARGURA_BIN-1:0]   desloc_d;
   logic [4*DIGITOS-1:0]     rascunho_q;
   logic [4*DIGITOS-1:0]     rascunho_d;
   logic [4*DIGITOS-1:0]     ajustado;
   logic [LarguraCont-1:0]   contador_q;
   logic                     estouro_pend_q;
   logic                     bit_sai;

   // Add-3 correction on every digit in parallel, then one left shift of {scratch, shiftreg}.
   always_comb begin
      ajustado = rascunho_q;
      for (int d = 0; d < int'(DIGITOS); d++) begin
         if (rascunho_q[4*d +: 4] >= 4'd5) begin
            ajustado[4*d +: 4] = rascunho_q[4*d +: 4] + 4'd3;
         end
      end
      {bit_sai, rascunho_d} = {ajustado, desloc_q[LARGURA_BIN-1]};
      desloc_d = desloc_q << 1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q       <= Ocioso;
         desloc_q       <= '0;
         rascunho_q     <= '0;
         contador_q     <= '0;
         estouro_pend_q <= 1'b0;
         ocupado        <= 1'b0;
         pronto         <= 1'b0;
         bcd            <= '0;
         estouro        <= 1'b0;
      end else begin
         pronto <= 1'b0;
         unique case (estado_q)
            Ocioso: begin
               if (inicio) begin
                  desloc_q       <= binario;
                  rascunho_q     <= '0;
                  contador_q     <= ContInicial;
                  estouro_pend_q <= 1'b0;
                  ocupado        <= 1'b1;
                  estado_q       <= Converte;
               end
            end
            Converte: begin
               desloc_q       <= desloc_d;
               rascunho_q     <= rascunho_d;
               // A carry out of the top digit means the value reached 10^DIGITOS.
               estouro_pend_q <= estouro_pend_q | bit_sai;
               contador_q     <= contador_q - ContUm;
               if (contador_q == ContUm) begin
                  bcd      <= rascunho_d;
                  estouro  <= estouro_pend_q | bit_sai;
                  pronto   <= 1'b1;
                  ocupado  <= 1'b0;
                  estado_q <= Ocioso;
               end
            end
            default: estado_q <= Ocioso;
         endcase
      end
   end

endmodule

// File: tb/tb_binario_para_bcd.sv
// Scoreboard bench for binario_para_bcd: a 3-digit and a 2-digit instance share clock and reset.
module tb_binario_para_bcd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inicio_a = 1'b0;
   logic        inicio_b = 1'b0;
   logic [7:0]  binario_a = '0;
   logic [7:0]  binario_b = '0;
   logic        ocupado_a, pronto_a, estouro_a;
   logic        ocupado_b, pronto_b, estouro_b;
   logic [11:0] bcd_a;
   logic [7:0]  bcd_b;

   int checks = 0;
   int passes = 0;

   // Expected results: {estouro, bcd padded to 12 bits}.
   logic [12:0] sb_a[$];
   logic [12:0] sb_b[$];
   logic        pronto_ant_a = 1'b0;
   logic        pronto_ant_b = 1'b0;

   always #5 clk = ~clk;

   binario_para_bcd #(.LARGURA_BIN(8), .DIGITOS(3)) dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .inicio  (inicio_a),
      .binario (binario_a),
      .ocupado (ocupado_a),
      .pronto  (pronto_a),
      .bcd     (bcd_a),
      .estouro (estouro_a)
   );

   binario_para_bcd #(.LARGURA_BIN(8), .DIGITOS(2)) dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .inicio  (inicio_b),
      .binario (binario_b),
      .ocupado (ocupado_b),
      .pronto  (pronto_b),
      .bcd     (bcd_b),
      .estouro (estouro_b)
   );

   task automatic chk(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
      checks++;
      if (obtido === esperado) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nome, obtido, esperado, $time);
   endtask

   function automatic logic [12:0] modelo(input int v, input int dig);
      int lim = 1;
      int r;
      logic [12:0] res = '0;
      for (int i = 0; i < dig; i++) lim *= 10;
      r = v % lim;
      for (int i = 0; i < dig; i++) begin
         res[4*i +: 4] = 4'(r % 10);
         r /= 10;
      end
      res[12] = (v >= lim);
      return res;
   endfunction

   // Monitor: pops one expectation per pronto pulse and checks digits stay decimal.
   always @(negedge clk) begin
      logic [12:0] esp;
      if (pronto_a) begin
         chk("pulso_pronto_a", 32'(pronto_ant_a), 32'd0);
         if (sb_a.size() == 0) begin
            checks++;
            $display("FAIL pronto_inesperado_a: got bcd %0h expected no result", bcd_a);
         end else begin
            esp = sb_a.pop_front();
            chk("resultado_a", {19'd0, estouro_a, bcd_a}, {19'd0, esp});
         end
         for (int d = 0; d < 3; d++) chk("digito_a", 32'(bcd_a[4*d +: 4] <= 4'd9), 32'd1);
      end
      if (pronto_b) begin
         chk("pulso_pronto_b", 32'(pronto_ant_b), 32'd0);
         if (sb_b.size() == 0) begin
            checks++;
            $display("FAIL pronto_inesperado_b: got bcd %0h expected no result", bcd_b);
         end else begin
            esp = sb_b.pop_front();
            chk("resultado_b", {19'd0, estouro_b, 4'd0, bcd_b}, {19'd0, esp});
         end
         for (int d = 0; d < 2; d++) chk("digito_b", 32'(bcd_b[4*d +: 4] <= 4'd9), 32'd1);
      end
      pronto_ant_a <= pronto_a;
      pronto_ant_b <= pronto_b;
   end

   // One conversion; binario is scrambled after the accept edge to prove the captured copy is used.
   task automatic converte(input bit sel, input int v, input logic [12:0] esp);
      int n;
      @(negedge clk);
      if (sel) begin
         inicio_b = 1'b1; binario_b = 8'(v); sb_b.push_back(esp);
      end else begin
         inicio_a = 1'b1; binario_a = 8'(v); sb_a.push_back(esp);
      end
      @(negedge clk);
      inicio_a = 1'b0;
      inicio_b = 1'b0;
      binario_a = binario_a ^ 8'hA5;
      binario_b = binario_b ^ 8'hA5;
      n = 0;
      while ((sel ? ocupado_b : ocupado_a) && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (sel) chk("ciclos_ocupado_b", 32'(n), 32'd8);
      else     chk("ciclos_ocupado_a", 32'(n), 32'd8);
   endtask

   initial begin
      int n;

      repeat (3) @(negedge clk);
      chk("reset_ocupado", 32'(ocupado_a), 32'd0);
      chk("reset_pronto", 32'(pronto_a), 32'd0);
      chk("reset_bcd", 32'(bcd_a), 32'd0);
      chk("reset_estouro", 32'(estouro_a), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      converte(1'b0, 0, 13'h0000);
      converte(1'b0, 255, 13'h0255);
      chk("bcd_estavel", 32'(bcd_a), 32'h255);

      // Back-to-back: inicio held high through pronto.
      @(negedge clk);
      inicio_a = 1'b1; binario_a = 8'd99; sb_a.push_back(13'h0099);
      n = 0;
      do begin @(negedge clk); n++; end while (!pronto_a && n < 40);
      chk("latencia_pronto", 32'(n), 32'd9);
      binario_a = 8'd128; sb_a.push_back(13'h0128);
      n = 0;
      do begin @(negedge clk); n++; end while (!pronto_a && n < 40);
      inicio_a = 1'b0;
      chk("intervalo_back_to_back", 32'(n), 32'd9);

      // A second inicio during conversion must be ignored.
      @(negedge clk);
      inicio_a = 1'b1; binario_a = 8'd200; sb_a.push_back(13'h0200);
      @(negedge clk);
      inicio_a = 1'b0;
      @(negedge clk);
      inicio_a = 1'b1; binario_a = 8'd7;
      @(negedge clk);
      inicio_a = 1'b0;
      n = 0;
      while (ocupado_a && n < 40) begin n++; @(negedge clk); end
      chk("ocupado_caiu", 32'(ocupado_a), 32'd0);
      repeat (12) @(negedge clk);
      chk("ignorado_bcd", 32'(bcd_a), 32'h200);

      // Reset mid-conversion aborts with no pronto.
      @(negedge clk);
      inicio_a = 1'b1; binario_a = 8'd255;
      @(negedge clk);
      inicio_a = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("aborto_ocupado", 32'(ocupado_a), 32'd0);
      chk("aborto_pronto", 32'(pronto_a), 32'd0);
      chk("aborto_bcd", 32'(bcd_a), 32'd0);
      chk("aborto_estouro", 32'(estouro_a), 32'd0);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("aborto_ocioso", 32'(ocupado_a), 32'd0);
      converte(1'b0, 42, 13'h0042);

      // Two-digit instance: overflow boundary and sticky clear.
      converte(1'b1, 99, 13'h0099);
      converte(1'b1, 100, 13'h1000);
      converte(1'b1, 255, 13'h1055);
      converte(1'b1, 9, 13'h0009);

      for (int v = 0; v < 256; v++) begin
         converte(1'b0, v, modelo(v, 3));
         converte(1'b1, v, modelo(v, 2));
      end

      repeat (3) @(negedge clk);
      chk("fila_a_vazia", 32'(sb_a.size()), 32'd0);
      chk("fila_b_vazia", 32'(sb_b.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish before limit");
      $fatal(1, "timeout");
   end

endmodule
